// File: rtl/mac_outer_array_2x2.sv
// 2x2 signed multiply-accumulate tile: each accepted slice computes y[i][j] = acc[i][j] + a[i]*b[j].
// Two register stages (products/acc capture, then accumulate); one slice per cycle, no backpressure.
module mac_outer_array_2x2 #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [A_W-1:0]   a0,
    input  logic signed [A_W-1:0]   a1,
    input  logic signed [B_W-1:0]   b0,
    input  logic signed [B_W-1:0]   b1,
    input  logic signed [ACC_W-1:0] acc00,
    input  logic signed [ACC_W-1:0] acc01,
    input  logic signed [ACC_W-1:0] acc10,
    input  logic signed [ACC_W-1:0] acc11,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] y00,
    output logic signed [ACC_W-1:0] y01,
    output logic signed [ACC_W-1:0] y10,
    output logic signed [ACC_W-1:0] y11
);

    localparam int P_W = A_W + B_W;

    // Sign-extend a full-precision product to the accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [P_W-1:0] p);
        return ACC_W'(p);
    endfunction

    // Two's complement wrapping accumulate of one cell.
    function automatic logic signed [ACC_W-1:0] mac_sum(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [P_W-1:0]   p
    );
        return acc + sext_prod(p);
    endfunction

    logic signed [A_W-1:0]   a_s      [2];
    logic signed [B_W-1:0]   b_s      [2];
    logic signed [ACC_W-1:0] acc_in_s [4];

    logic signed [P_W-1:0]   prod_d [4];
    logic signed [P_W-1:0]   prod_q [4];
    logic signed [ACC_W-1:0] acc_d  [4];
    logic signed [ACC_W-1:0] acc_q  [4];
    logic                    v1_d;
    logic                    v1_q;

    logic signed [ACC_W-1:0] y_d [4];
    logic signed [ACC_W-1:0] y_q [4];
    logic                    out_valid_d;
    logic                    out_valid_q;

    assign a_s[0]      = a0;
    assign a_s[1]      = a1;
    assign b_s[0]      = b0;
    assign b_s[1]      = b1;
    assign acc_in_s[0] = acc00;
    assign acc_in_s[1] = acc01;
    assign acc_in_s[2] = acc10;
    assign acc_in_s[3] = acc11;

    // Stage 1 next state: capture products and partial sums only for a valid slice,
    // so undriven operands on idle cycles never reach the data registers.
    always_comb begin
        v1_d   = in_valid;
        prod_d = prod_q;
        acc_d  = acc_q;
        if (in_valid) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    prod_d[2*i+j] = P_W'(a_s[i]) * P_W'(b_s[j]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                acc_d[k] = acc_in_s[k];
            end
        end else begin
            v1_d = 1'b0;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                prod_q[k] <= '0;
                acc_q[k]  <= '0;
            end
        end else begin
            v1_q <= v1_d;
            for (int k = 0; k < 4; k++) begin
                prod_q[k] <= prod_d[k];
                acc_q[k]  <= acc_d[k];
            end
        end
    end

    // Stage 2 next state: accumulate when stage 1 holds a slice, otherwise keep the last result.
    always_comb begin
        out_valid_d = v1_q;
        y_d         = y_q;
        if (v1_q) begin
            for (int k = 0; k < 4; k++) begin
                y_d[k] = mac_sum(acc_q[k], prod_q[k]);
            end
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Stage 2 registers (tile outputs).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            for (int k = 0; k < 4; k++) begin
                y_q[k] <= y_d[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y00       = y_q[0];
    assign y01       = y_q[1];
    assign y10       = y_q[2];
    assign y11       = y_q[3];

endmodule

// File: tb/tb_mac_outer_array_2x2.sv
// Randomised and directed bench for mac_outer_array_2x2 against a plain-arithmetic reference
// with a two-slice latency queue.
module tb_mac_outer_array_2x2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [7:0]  a0, a1, b0, b1;
    logic signed [31:0] acc00, acc01, acc10, acc11;
    logic               out_valid;
    logic signed [31:0] y00, y01, y10, y11;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic         v;
        logic [127:0] y;
    } slot_t;

    slot_t        pipe[$];
    logic         exp_v = 1'b0;
    logic [127:0] exp_y = 128'd0;
    logic [127:0] dut_y;

    assign dut_y = {y00, y01, y10, y11};

    mac_outer_array_2x2 #(.A_W(8), .B_W(8), .ACC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .acc00(acc00), .acc01(acc01), .acc10(acc10), .acc11(acc11),
        .out_valid(out_valid),
        .y00(y00), .y01(y01), .y10(y10), .y11(y11)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_cell(input logic signed [7:0] a, input logic signed [7:0] b,
                                             input logic signed [31:0] acc);
        longint s;
        s = longint'(acc) + longint'(a) * longint'(b);
        return s[31:0];
    endfunction

    function automatic logic signed [7:0] r8();
        return 8'($urandom_range(255, 0));
    endfunction

    // Drive one cycle of inputs at a falling edge, advance to the next falling edge and update the model.
    task automatic cycle(input logic v, input logic signed [7:0] ia0, ia1, ib0, ib1,
                         input logic signed [31:0] c00, c01, c10, c11);
        slot_t s;
        in_valid = v;
        if (v) begin
            a0 = ia0; a1 = ia1; b0 = ib0; b1 = ib1;
            acc00 = c00; acc01 = c01; acc10 = c10; acc11 = c11;
            s.v = rst_n;
            s.y = {ref_cell(ia0, ib0, c00), ref_cell(ia0, ib1, c01),
                   ref_cell(ia1, ib0, c10), ref_cell(ia1, ib1, c11)};
        end else begin
            a0 = {8{1'bx}}; a1 = {8{1'bx}}; b0 = {8{1'bx}}; b1 = {8{1'bx}};
            acc00 = {32{1'bx}}; acc01 = {32{1'bx}}; acc10 = {32{1'bx}}; acc11 = {32{1'bx}};
            s.v = 1'b0;
            s.y = 128'd0;
        end
        pipe.push_back(s);
        @(negedge clk);
        if (!rst_n) begin
            pipe.delete();
            exp_v = 1'b0;
            exp_y = 128'd0;
        end else if (pipe.size() == 2) begin
            s = pipe.pop_front();
            exp_v = s.v;
            if (s.v) exp_y = s.y;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0);
    endtask

    task automatic rand_cycle(input logic v);
        cycle(v, r8(), r8(), r8(), r8(), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_cycle(1'b1);
            vectors++;
            if (out_valid !== 1'b0 || dut_y !== 128'd0) begin
                miscompares++;
                $display("FAIL reset: out_valid=%b y=%h, required out_valid=0 y=0", out_valid, dut_y);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_gemm();
        cycle(1'b1, 8'sd1, 8'sd3, 8'sd5, 8'sd6, 32'sd0, 32'sd0, 32'sd0, 32'sd0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gemm_latency: out_valid=%b after one edge, required 0", out_valid);
        end
        cycle(1'b1, 8'sd2, 8'sd4, 8'sd7, 8'sd8, 32'sd5, 32'sd6, 32'sd15, 32'sd18);
        vectors++;
        if (out_valid !== 1'b1 || dut_y !== {32'sd5, 32'sd6, 32'sd15, 32'sd18}) begin
            miscompares++;
            $display("FAIL gemm_slice1: out_valid=%b y=%h, required 1 y=(5,6,15,18)", out_valid, dut_y);
        end
        idle();
        vectors++;
        if (out_valid !== 1'b1 || dut_y !== {32'sd19, 32'sd22, 32'sd43, 32'sd50}) begin
            miscompares++;
            $display("FAIL gemm_slice2: out_valid=%b y=%h, required 1 y=(19,22,43,50)", out_valid, dut_y);
        end
        idle();
        vectors++;
        if (out_valid !== 1'b0 || dut_y !== {32'sd19, 32'sd22, 32'sd43, 32'sd50}) begin
            miscompares++;
            $display("FAIL gemm_hold: out_valid=%b y=%h, required 0 y=(19,22,43,50)", out_valid, dut_y);
        end
    endtask

    task automatic test_extremes();
        cycle(1'b1, -8'sd128, 8'sd127, -8'sd128, -8'sd128, 32'sd0, 32'sd0, 32'sd0, -32'sd1);
        idle();
        vectors++;
        if (out_valid !== 1'b1 || y00 !== 32'sd16384 || y11 !== -32'sd16257) begin
            miscompares++;
            $display("FAIL extremes: out_valid=%b y00=%0d y11=%0d, required 1 16384 -16257",
                     out_valid, y00, y11);
        end
        vectors++;
        if (dut_y !== exp_y) begin
            miscompares++;
            $display("FAIL extremes_all: y=%h, required %h", dut_y, exp_y);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 8'sd1, 8'sd0, 8'sd1, 8'sd0, 32'sh7fffffff, 32'sd0, 32'sd0, 32'sd0);
        idle();
        vectors++;
        if (out_valid !== 1'b1 || y00 !== 32'sh80000000) begin
            miscompares++;
            $display("FAIL wrap: out_valid=%b y00=%h, required 1 80000000", out_valid, y00);
        end
    endtask

    task automatic test_back_to_back();
        int highs;
        logic [127:0] third;
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) rand_cycle(1'b1);
            else idle();
            if (out_valid === 1'b1) highs++;
            vectors++;
            if (out_valid !== exp_v || dut_y !== exp_y) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: out_valid=%b y=%h, required %b %h",
                         i, out_valid, dut_y, exp_v, exp_y);
            end
            if (i == 3) third = exp_y;
        end
        vectors++;
        if (highs != 3 || dut_y !== third) begin
            miscompares++;
            $display("FAIL back_to_back_count: pulses=%0d y=%h, required 3 %h", highs, dut_y, third);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rand_cycle(1'($urandom_range(1, 0)));
            vectors++;
            if (out_valid !== exp_v || dut_y !== exp_y) begin
                miscompares++;
                $display("FAIL random[%0d]: out_valid=%b y=%h, required %b %h",
                         i, out_valid, dut_y, exp_v, exp_y);
            end
        end
    endtask

    task automatic test_midflight_reset();
        cycle(1'b1, 8'sd3, 8'sd3, 8'sd3, 8'sd3, 32'sd0, 32'sd0, 32'sd0, 32'sd0);
        idle();
        idle();
        vectors++;
        if (dut_y !== {32'sd9, 32'sd9, 32'sd9, 32'sd9}) begin
            miscompares++;
            $display("FAIL midflight_pre: y=%h, required all 9", dut_y);
        end
        rand_cycle(1'b1);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || dut_y !== 128'd0) begin
            miscompares++;
            $display("FAIL midflight_async: out_valid=%b y=%h, required 0 0", out_valid, dut_y);
        end
        pipe.delete();
        exp_v = 1'b0;
        exp_y = 128'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            vectors++;
            if (out_valid !== 1'b0 || dut_y !== 128'd0) begin
                miscompares++;
                $display("FAIL midflight_release[%0d]: out_valid=%b y=%h, required 0 0",
                         i, out_valid, dut_y);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_gemm();
        test_extremes();
        test_wrap();
        test_back_to_back();
        test_random();
        test_midflight_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
